// File: rtl/counter_sweep_ctrl.sv
// Triangle-sweep sequencer for an up/down count datapath: lo -> hi -> lo,
// optional dwell at each turning point, repeated n_sweeps times.
module counter_sweep_ctrl #(
    parameter int WIDTH   = 4,
    parameter int DWELL_W = 4,
    parameter int NSW_W   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [WIDTH-1:0]   lo,
    input  logic [WIDTH-1:0]   hi,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NSW_W-1:0]   n_sweeps,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [NSW_W-1:0]   sweeps_done
);

    typedef enum logic [2:0] {IDLE, UP, DWELL_HI, DOWN, DWELL_LO, DONE} state_t;

    localparam logic [WIDTH-1:0]   C_ONE = 1;
    localparam logic [DWELL_W-1:0] T_ONE = 1;
    localparam logic [NSW_W-1:0]   S_ONE = 1;

    state_t             state;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [NSW_W-1:0]   nsw_q;
    logic [DWELL_W-1:0] timer;

    logic [WIDTH-1:0]   count_inc;
    logic [WIDTH-1:0]   count_dec;
    logic [NSW_W-1:0]   sweeps_inc;

    always_comb begin
        count_inc  = count + C_ONE;
        count_dec  = count - C_ONE;
        sweeps_inc = sweeps_done + S_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            count       <= '0;
            dir         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cfg_err     <= 1'b0;
            sweeps_done <= '0;
            timer       <= '0;
            lo_q        <= '0;
            hi_q        <= '0;
            dwell_q     <= '0;
            nsw_q       <= '0;
        end else begin
            done    <= 1'b0;
            cfg_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        lo_q    <= lo;
                        hi_q    <= hi;
                        dwell_q <= dwell;
                        nsw_q   <= n_sweeps;
                        if (lo >= hi || n_sweeps == '0) begin
                            cfg_err <= 1'b1;
                        end else begin
                            count       <= lo;
                            dir         <= 1'b0;
                            sweeps_done <= '0;
                            busy        <= 1'b1;
                            state       <= UP;
                        end
                    end
                end
                UP: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count_inc;
                        if (count_inc == hi_q) begin
                            if (dwell_q != '0) begin
                                state <= DWELL_HI;
                                timer <= dwell_q;
                            end else begin
                                state <= DOWN;
                                dir   <= 1'b1;
                            end
                        end
                    end
                end
                DWELL_HI: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - T_ONE;
                        if (timer == T_ONE) begin
                            state <= DOWN;
                            dir   <= 1'b1;
                        end
                    end
                end
                DOWN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        count <= count_dec;
                        // Reaching lo closes one full up+down sweep.
                        if (count_dec == lo_q) begin
                            sweeps_done <= sweeps_inc;
                            if (sweeps_inc == nsw_q) begin
                                state <= DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else if (dwell_q != '0) begin
                                state <= DWELL_LO;
                                timer <= dwell_q;
                            end else begin
                                state <= UP;
                                dir   <= 1'b0;
                            end
                        end
                    end
                end
                DWELL_LO: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - T_ONE;
                        if (timer == T_ONE) begin
                            state <= UP;
                            dir   <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
